// File: rtl/full_adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
package full_adder_pkg;

    localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit gate-level full-adder cell built from XOR/AND/OR primitives.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;
    logic g;
    logic pc;

    xor u_xor_p (p, a, b);
    xor u_xor_s (s, p, ci);
    and u_and_g (g, a, b);
    and u_and_pc (pc, ci, p);
    or  u_or_co (co, g, pc);

endmodule

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder with a combinational result and a registered copy.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [WIDTH-1:0] sum_q,
    output logic             c_out_q
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             c_out_d;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign c_out = carry[WIDTH];

    always_comb begin
        sum_d   = sum;
        c_out_d = c_out;
    end

    // Reset clears only the registered copy; the ripple chain stays live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed and exhaustive checks of full_adder at WIDTH 8, plus a WIDTH 4 instance.
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       c_in = 1'b0;
    logic [7:0] sum;
    logic       c_out;
    logic [7:0] sum_q;
    logic       c_out_q;

    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       c_in4 = 1'b0;
    logic [3:0] sum4;
    logic       c_out4;
    logic [3:0] sum_q4;
    logic       c_out_q4;

    int checks = 0;
    int errors = 0;

    full_adder #(.WIDTH(8)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c_in    (c_in),
        .sum     (sum),
        .c_out   (c_out),
        .sum_q   (sum_q),
        .c_out_q (c_out_q)
    );

    full_adder #(.WIDTH(4)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .a       (a4),
        .b       (b4),
        .c_in    (c_in4),
        .sum     (sum4),
        .c_out   (c_out4),
        .sum_q   (sum_q4),
        .c_out_q (c_out_q4)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a    = av;
        b    = bv;
        c_in = cv;
        #10;
    endtask

    int exp_val;

    initial begin
        // Reset state before any clock edge
        #10;
        check("reset_sum_q", {24'b0, sum_q}, 32'h0);
        check("reset_c_out_q", {31'b0, c_out_q}, 32'h0);
        apply(8'h12, 8'h34, 1'b1);
        check("comb_during_rst", {23'b0, c_out, sum}, 32'h047);

        // Corner cases
        apply(8'hFF, 8'h00, 1'b1);
        check("ff_00_1", {23'b0, c_out, sum}, 32'h100);
        apply(8'hFF, 8'hFF, 1'b1);
        check("ff_ff_1", {23'b0, c_out, sum}, 32'h1FF);
        apply(8'h00, 8'h00, 1'b0);
        check("00_00_0", {23'b0, c_out, sum}, 32'h000);
        apply(8'h7F, 8'h00, 1'b1);
        check("ripple_7f", {23'b0, c_out, sum}, 32'h080);
        apply(8'h80, 8'h80, 1'b0);
        check("ripple_80", {23'b0, c_out, sum}, 32'h100);
        apply(8'hAA, 8'h55, 1'b0);
        check("aa_55_0", {23'b0, c_out, sum}, 32'h0FF);
        apply(8'hAA, 8'h55, 1'b1);
        check("aa_55_1", {23'b0, c_out, sum}, 32'h100);

        // WIDTH=4 instance
        a4 = 4'hF; b4 = 4'h1; c_in4 = 1'b0;
        #10;
        check("w4_f_1_0", {27'b0, c_out4, sum4}, 32'h10);
        a4 = 4'h5; b4 = 4'h6; c_in4 = 1'b1;
        #10;
        check("w4_5_6_1", {27'b0, c_out4, sum4}, 32'h0C);

        // Register latency
        @(negedge clk);
        rst = 1'b0;
        apply(8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("cap_zero", {23'b0, c_out_q, sum_q}, 32'h000);
        @(negedge clk);
        apply(8'h12, 8'h34, 1'b1);
        check("latency_comb", {23'b0, c_out, sum}, 32'h047);
        check("latency_pre_edge", {23'b0, c_out_q, sum_q}, 32'h000);
        @(posedge clk);
        #1;
        check("latency_sum_q", {24'b0, sum_q}, 32'h47);
        check("latency_c_out_q", {31'b0, c_out_q}, 32'h0);
        check("w4_cap", {27'b0, c_out_q4, sum_q4}, 32'h0C);

        @(negedge clk);
        apply(8'hF0, 8'h20, 1'b0);
        @(posedge clk);
        #1;
        check("cap_carry", {23'b0, c_out_q, sum_q}, 32'h110);

        // Asynchronous reset between edges
        #20;
        rst = 1'b1;
        #1;
        check("async_rst_sum_q", {24'b0, sum_q}, 32'h00);
        check("async_rst_c_out_q", {31'b0, c_out_q}, 32'h0);
        check("async_rst_comb", {23'b0, c_out, sum}, 32'h110);
        apply(8'h0F, 8'h01, 1'b0);
        check("rst_comb_track", {23'b0, c_out, sum}, 32'h010);
        @(posedge clk);
        #1;
        check("rst_hold", {23'b0, c_out_q, sum_q}, 32'h000);
        @(negedge clk);
        rst = 1'b0;
        apply(8'hC0, 8'h50, 1'b1);
        check("post_rst_pre_edge", {23'b0, c_out_q, sum_q}, 32'h000);
        @(posedge clk);
        #1;
        check("post_rst_capture", {23'b0, c_out_q, sum_q}, 32'h111);

        // Exhaustive sweep over {c_in, a, b}
        for (int i = 0; i < 131072; i++) begin
            a    = i[15:8];
            b    = i[7:0];
            c_in = i[16];
            #10;
            exp_val = int'(a) + int'(b) + int'(c_in);
            check("sweep", {23'b0, c_out, sum}, exp_val);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/full_adder.md
# full_adder

Parameterised ripple-carry binary adder: two WIDTH-bit operands plus a carry-in produce a WIDTH-bit sum and carry-out. The primary result is purely combinational and built from explicit per-bit gate-level full-adder cells, so it suits gate-level synthesis and optimisation flows. A registered copy of the result is also provided for downstream synchronous logic. The block is a leaf arithmetic unit with no handshake.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal for any value ≥ 1.
- clk  input  1  clock; used only by the registered result copy.
- rst  input  1  asynchronous, active-high reset; clears the registered copy only.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry-in.
- sum  output  WIDTH  combinational sum, bits [WIDTH-1:0] of a + b + c_in.
- c_out  output  1  combinational carry-out, bit WIDTH of a + b + c_in.
- sum_q  output  WIDTH  sum registered on the rising edge of clk.
- c_out_q  output  1  c_out registered on the rising edge of clk.

## Operation
- {c_out, sum} = a + b + c_in, computed exactly at WIDTH+1 bits. Overflow never wraps silently; it appears on c_out.
- Ripple chain: carry[0] = c_in; for each bit i, sum[i] = a[i] ^ b[i] ^ carry[i] and carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i])). c_out = carry[WIDTH].
- Operands are unsigned. Signed interpretation is the user's concern. Two's-complement results are still bit-correct in sum.
- sum and c_out do not depend on clk or rst. They are valid whenever the inputs are stable, including while rst is asserted.
- Any X or Z on an input bit may propagate to the affected sum bits and upward through the carry chain. With known inputs, all outputs are known (no X).

## Timing
- sum and c_out: zero-cycle combinational path. Worst case is the full carry ripple from c_in or bit 0 to c_out, WIDTH cell delays. Outputs must settle within one input-update interval; the test bench samples 10 time units after changing inputs.
- sum_q and c_out_q: one-cycle latency. They capture {c_out, sum} at each rising edge of clk.
- Reset: when rst is asserted, sum_q = 0 and c_out_q = 0 immediately, without waiting for clk. They hold at 0 while rst is high. Capture resumes at the first rising edge after rst deasserts.
- Reset asserted mid-operation clears only the registered copy. The combinational outputs are unaffected.

## Structure
- Sub-module full_adder_cell: 1-bit gate-level cell with ports a, b, ci, s, co, implementing the two equations above using XOR/AND/OR primitives only. Instantiate it WIDTH times in a generate loop and chain the carries.
- The top level contains the carry vector, the generate loop and the output register process.
- Shared package: holds only the default WIDTH constant (8). No typedefs are required.

## Test plan
- Exhaustive sweep at WIDTH = 8: drive all 131072 combinations of {a, b, c_in}, wait 10 units -> {c_out, sum} equals a + b + c_in exactly, with no X.
- Corner cases: a=0xFF, b=0x00, c_in=1 -> sum=0x00, c_out=1. a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1. a=0, b=0, c_in=0 -> sum=0, c_out=0.
- Full carry ripple: a=0x7F, b=0x00, c_in=1 -> sum=0x80, c_out=0. Then a=0x80, b=0x80, c_in=0 -> sum=0x00, c_out=1.
- Register latency: apply a=0x12, b=0x34, c_in=1 before a clk rising edge -> after that edge, sum_q=0x47 and c_out_q=0, while sum already equals 0x47 combinationally.
- Asynchronous reset: with sum_q nonzero, raise rst between clock edges -> sum_q=0 and c_out_q=0 at once. sum and c_out still track the inputs. Deassert rst -> the next edge captures the current result.
- Width parameter: with WIDTH=4, a=0xF, b=0x1, c_in=0 -> sum=0x0, c_out=1.
